// File: rtl/riscv_ctrl_pkg.sv
// Shared types and helpers for the RV32I fetch/PC control path.
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        StBoot,
        StFetchReq,
        StFetchWait,
        StExec,
        StHalt
    } ctrl_state_e;

    localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;
    localparam logic [31:0] INSN_BYTES  = 32'd4;

    // Instruction fetch requires word alignment.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return |(addr & 32'h0000_0003);
    endfunction

endpackage

// File: rtl/pc_target_sel.sv
// Selects the PC that follows a retiring instruction: sequential, redirect, or trap vector.
module pc_target_sel
    import riscv_ctrl_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic [31:0] trap_vector,
    output logic [31:0] target,
    output logic        misaligned
);

    logic [31:0] seq_pc;
    logic [31:0] raw_target;

    always_comb begin
        seq_pc     = pc + INSN_BYTES;
        raw_target = redirect_valid ? redirect_target : seq_pc;
        // Sequential PC+4 stays aligned (and wraps silently), so only redirects can trap.
        misaligned = redirect_valid && is_misaligned(raw_target);
        target     = misaligned ? trap_vector : raw_target;
    end

endmodule

// File: rtl/pc_fetch_controller.sv
// PC sequencing and instruction fetch FSM with redirect, trap, halt/resume and retire count.
module pc_fetch_controller
    import riscv_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    output logic [31:0] PC_Next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt_req,
    input  logic        resume,
    output logic        halted,
    output logic        trap,
    output logic [31:0] trap_addr,
    output logic [31:0] retired
);

    ctrl_state_e state_q;
    logic [31:0] instr_q;
    logic        instr_valid_q;
    logic [31:0] trap_addr_q;
    logic [31:0] retired_q;

    logic [31:0] sel_target;
    logic        sel_misaligned;
    logic        retire;

    pc_target_sel u_target_sel (
        .pc              (PC),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_vector     (TRAP_VECTOR),
        .target          (sel_target),
        .misaligned      (sel_misaligned)
    );

    assign retire = (state_q == StExec) && exec_done;

    always_comb begin
        PC_Next = PC;
        case (state_q)
            StBoot:  PC_Next = RESET_VECTOR;
            StExec:  if (exec_done) PC_Next = sel_target;
            default: PC_Next = PC;
        endcase
    end

    assign imem_req    = (state_q == StFetchReq);
    assign imem_addr   = PC;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign halted      = (state_q == StHalt);
    assign trap        = retire && sel_misaligned;
    assign trap_addr   = trap_addr_q;
    assign retired     = retired_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StBoot;
            instr_q       <= 32'h0;
            instr_valid_q <= 1'b0;
            trap_addr_q   <= 32'h0;
            retired_q     <= 32'h0;
        end else begin
            case (state_q)
                StBoot: state_q <= StFetchReq;
                StFetchReq: begin
                    if (imem_ready) state_q <= StFetchWait;
                end
                StFetchWait: begin
                    if (imem_rvalid) begin
                        instr_q       <= imem_rdata;
                        instr_valid_q <= 1'b1;
                        state_q       <= StExec;
                    end
                end
                StExec: begin
                    if (exec_done) begin
                        retired_q     <= retired_q + 32'd1;
                        instr_valid_q <= 1'b0;
                        // A misaligned target can only come from a redirect.
                        if (sel_misaligned) trap_addr_q <= redirect_target;
                        // halt_req is only honoured at the instruction boundary.
                        if (instr_q == EBREAK_INSN || halt_req) state_q <= StHalt;
                        else state_q <= StFetchReq;
                    end
                end
                StHalt: begin
                    if (resume) state_q <= StFetchReq;
                end
                default: state_q <= StBoot;
            endcase
        end
    end

endmodule

// File: doc/pc_fetch_controller.md
Name: pc_fetch_controller

Overview:
- Sequences the RV32I program counter and instruction fetch for the core.
- Drives PC_Next into the Program_Counter register and reads back its PC.
- Issues a req/ready fetch to instruction memory with variable-latency response, and holds the fetched instruction for the datapath until it reports completion.
- Handles branch/jump redirects, misaligned-target traps, EBREAK/external halt and resume, and counts retired instructions.

Parameters:
RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
TRAP_VECTOR, 32'h0000_0100, PC loaded on misaligned redirect target.

Ports:
clk  in  1  core clock, rising edge.
rst  in  1  asynchronous reset, active-low (0 = reset).
PC  in  32  current PC from Program_Counter.
PC_Next  out  32  next PC to Program_Counter (combinational).
imem_req  out  1  fetch request.
imem_addr  out  32  fetch address (= PC).
imem_ready  in  1  memory accepts request this cycle.
imem_rvalid  in  1  fetch data valid.
imem_rdata  in  32  fetched instruction.
instr  out  32  latched instruction to decoder.
instr_valid  out  1  instr holds a live instruction.
exec_done  in  1  datapath finished current instruction (single-cycle pulse).
redirect_valid  in  1  taken branch/jump, qualified by exec_done.
redirect_target  in  32  branch/jump target.
halt_req  in  1  external halt request (level).
resume  in  1  leave HALT (pulse).
halted  out  1  controller in HALT.
trap  out  1  one-cycle pulse on misaligned target.
trap_addr  out  32  offending target of last trap.
retired  out  32  retired-instruction count, wraps 2^32-1 -> 0.

Behaviour:
- Reset (rst=0, async): state BOOT; imem_req=0, instr=0, instr_valid=0, halted=0, trap=0, trap_addr=0, retired=0. imem_addr follows PC.
- States: BOOT, FETCH_REQ, FETCH_WAIT, EXEC, HALT.
- BOOT: PC_Next=RESET_VECTOR for exactly one cycle after reset release. Next state FETCH_REQ.
- FETCH_REQ: imem_req=1, PC_Next=PC. When imem_ready=1, go to FETCH_WAIT. imem_rvalid is ignored in this state.
- FETCH_WAIT: imem_req=0, PC_Next=PC. On imem_rvalid: instr<=imem_rdata, instr_valid<=1, go to EXEC. Minimum fetch latency is 2 cycles (accept, then rvalid the following cycle or later).
- EXEC, exec_done=0: PC_Next=PC; instr_valid remains 1.
- EXEC, exec_done=1:
  - retired increments.
  - Target T = redirect_valid ? redirect_target : PC+4 (mod 2^32).
  - If redirect_valid and T[1:0]!=0: PC_Next=TRAP_VECTOR, trap=1 for that cycle, trap_addr<=T.
  - Otherwise PC_Next=T.
  - instr_valid<=0.
  - Next state is HALT if instr==32'h0010_0073 (EBREAK) or halt_req=1; else FETCH_REQ.
- HALT: halted=1, PC_Next=PC, no fetch. On resume, go to FETCH_REQ. halt_req held high does not block resume; it takes effect again only at the next instruction boundary.
- halt_req is sampled only at exec_done; a halt during a fetch completes the fetch and the instruction first.
- Redirect plus halt in the same cycle: PC_Next takes the redirect (or trap) value, then HALT. A trap does not halt by itself.
- exec_done, redirect_valid and resume outside their owning state are ignored.
- Reset mid-fetch: the outstanding response is dropped. rvalid arriving in BOOT/FETCH_REQ is ignored; memory must drop the request when imem_req falls.
- PC+4 at 32'hFFFF_FFFC wraps to 0, no trap.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state enum type;
  - EBREAK_INSN = 32'h0010_0073;
  - INSN_BYTES = 4;
  - alignment-check function is_misaligned(addr).
- One combinational sub-module, pc_target_sel: inputs PC, redirect_valid, redirect_target, TRAP_VECTOR; outputs target and misaligned flag.
- The FSM, instruction latch and retire counter stay in pc_fetch_controller.

Test Plan:
- Release reset, imem_ready=1 immediately, rvalid 1 cycle later, rdata=32'h0000_0013, exec_done 1 cycle after instr_valid → PC sequence 0, 4, 8; retired=3 after three instructions; imem_addr matches PC at each req.
- imem_ready withheld 3 cycles, rvalid 4 cycles after accept → imem_req stays high until ready; PC stable; instr_valid rises only in the rvalid+1 cycle.
- At PC=8, exec_done with redirect_valid=1, target=32'h40 → next PC=32'h40. Then target=32'h42 → PC=32'h100, trap pulses once, trap_addr=32'h42.
- Fetch EBREAK at PC=32'h10 → halted=1 after exec_done, PC=32'h14, no imem_req. resume pulse → fetch from 32'h14.
- halt_req asserted during FETCH_WAIT → instruction completes, retired increments, then HALT. Simultaneous redirect to 32'h80 plus halt_req → halted with PC=32'h80.
- Assert rst=0 asynchronously mid-FETCH_WAIT → imem_req and instr_valid drop immediately. A stale rvalid one cycle after release is ignored; first fetch is at RESET_VECTOR and retired=0.
